// File: rtl/mem_request_responder.sv
// Fixed-latency 128-bit memory responder with an in-flight limit and in-order completions.
// Optional macro RESPONDER_STALL_INJECT_EN adds LFSR-driven pseudo-random busy stalls.
module mem_request_responder #(
    parameter int ADDR_BITS       = 10,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [23:0]   memrequest_addr,
    input  logic          memrequest_en,
    input  logic          memrequest_write_enable,
    input  logic [127:0]  memrequest_write_data,
    output logic          memrequest_busy,
    output logic          memrequest_complete,
    output logic [127:0]  memrequest_resp_data,
    output logic [3:0]    outstanding_count
);

    logic [127:0]         mem [2**ADDR_BITS];

    logic [LATENCY-1:0]   valid_q, valid_d;
    logic [LATENCY-1:0]   isRead_q, isRead_d;
    logic [127:0]         data_q [LATENCY];
    logic [127:0]         data_d [LATENCY];
    logic [3:0]           count_q, count_d;

    logic [ADDR_BITS-1:0] wordAddr;
    logic                 accept;
    logic                 retire;
    logic                 limitBusy;
    logic                 stallBusy;
    logic                 unusedAddrBits;

    assign wordAddr       = memrequest_addr[ADDR_BITS-1:0];
    assign unusedAddrBits = ^memrequest_addr[23:ADDR_BITS];

`ifdef RESPONDER_STALL_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stallBusy = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stallBusy = 1'b0;
`endif

    // Busy looks only at the registered count, so a completion on the same edge never frees a slot early.
    assign limitBusy       = (count_q == 4'(MAX_OUTSTANDING));
    assign memrequest_busy = !rst && (limitBusy || stallBusy);
    assign accept          = memrequest_en && !memrequest_busy && !rst;
    assign retire          = valid_q[LATENCY-1];

    assign memrequest_complete  = !rst && retire;
    assign memrequest_resp_data = (memrequest_complete && isRead_q[LATENCY-1]) ? data_q[LATENCY-1] : '0;
    assign outstanding_count    = rst ? 4'd0 : count_q;

    always_comb begin
        valid_d  = {valid_q[LATENCY-2:0], accept};
        isRead_d = {isRead_q[LATENCY-2:0], accept && !memrequest_write_enable};
        data_d[0] = (accept && !memrequest_write_enable) ? mem[wordAddr] : '0;
        for (int i = 1; i < LATENCY; i++) begin
            data_d[i] = data_q[i-1];
        end
        count_d = count_q;
        case ({accept, retire})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= 4'd0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Payload stages need no reset; they are only observed through their valid bit.
    always_ff @(posedge clk) begin
        isRead_q <= isRead_d;
        for (int i = 0; i < LATENCY; i++) begin
            data_q[i] <= data_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && memrequest_write_enable) begin
            mem[wordAddr] <= memrequest_write_data;
        end
    end

endmodule
